jtag_xfer_seq: RTL

Transfer sequencer that sits directly upstream of the JTAG pin interface (jtagIF). It turns one DAP-level request (AP/DP register read or write, ID read, or chain reset) into the required sequence of jtagIF commands: IR selection, the DR transfer, the RDBUFF read that returns posted read data, and WAIT retries. It reports one final ACK and one data word per request to the command controller above.

---
 rtl/jtag_xfer_seq.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_xfer_seq.sv
// Turns one DAP-level request into a sequence of jtagIF launches.
// Covered sequences: IR select, DR transfer, RDBUFF read-back, WAIT retry, chain reset, ID read.
module jtag_xfer_seq #(
  parameter logic [15:0] WAITMAX = 16'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_go,
  input  logic [1:0]  req_op,
  input  logic        req_rnw,
  input  logic        req_apndp,
  input  logic [1:0]  req_addr32,
  input  logic [31:0] req_wdata,
  input  logic [15:0] wait_retries,
  output logic        req_busy,
  output logic        req_done,
  output logic [2:0]  req_ack,
  output logic [31:0] req_rdata,
  output logic [1:0]  cmd,
  output logic [3:0]  ir,
  output logic        rnw,
  output logic        apndp,
  output logic [1:0]  addr32,
  output logic [31:0] dwrite,
  output logic        go,
  input  logic        idle,
  input  logic [2:0]  ack,
  input  logic [31:0] dread
);

  localparam logic [1:0] CMD_IR  = 2'd0;
  localparam logic [1:0] CMD_TFR = 2'd1;
  localparam logic [1:0] CMD_RID = 2'd2;
  localparam logic [1:0] CMD_RST = 2'd3;

  localparam logic [3:0] IR_DPACC  = 4'hA;
  localparam logic [3:0] IR_APACC  = 4'hB;
  localparam logic [3:0] IR_IDCODE = 4'hE;

  localparam logic [2:0] ACK_WAIT = 3'b001;
  localparam logic [2:0] ACK_OK   = 3'b010;
  localparam logic [2:0] ACK_RSVD = 3'b111;

  // CRST and RDID carry the RESET and READID launches of the reset/ID requests.
  typedef enum logic [2:0] {IDLE, SETIR, XFER, RDBUF, DONE, CRST, RDID} state_e;
  typedef enum logic {L_GO, L_RUN} lph_e;

  state_e      state_q, state_d, ret_q, ret_d, nst;
  lph_e        lph_q, lph_d;
  logic        go_q, go_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [3:0]  ir_q, ir_d;
  logic        rnw_q, rnw_d, apndp_q, apndp_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] dwrite_q, dwrite_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [2:0]  rack_q, rack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cvld_q, cvld_d;
  logic [3:0]  cir_q, cir_d, tir_q, tir_d;
  logic [1:0]  op_q, op_d;
  logic        lrnw_q, lrnw_d, lapndp_q, lapndp_d;
  logic [1:0]  laddr_q, laddr_d;
  logic [31:0] lwdata_q, lwdata_d;
  logic [15:0] cnt_q, cnt_d, lim_q, lim_d;
  logic        start, fin;
  logic [2:0]  fin_ack;

  assign req_busy  = busy_q;
  assign req_done  = done_q;
  assign req_ack   = rack_q;
  assign req_rdata = rdata_q;
  assign cmd       = cmd_q;
  assign ir        = ir_q;
  assign rnw       = rnw_q;
  assign apndp     = apndp_q;
  assign addr32    = addr_q;
  assign dwrite    = dwrite_q;
  assign go        = go_q;

  always_comb begin
    state_d  = state_q;   ret_d    = ret_q;    lph_d   = lph_q;
    go_d     = go_q;      cmd_d    = cmd_q;    ir_d    = ir_q;
    rnw_d    = rnw_q;     apndp_d  = apndp_q;  addr_d  = addr_q;
    dwrite_d = dwrite_q;  busy_d   = busy_q;   done_d  = 1'b0;
    rack_d   = rack_q;    rdata_d  = rdata_q;  cvld_d  = cvld_q;
    cir_d    = cir_q;     tir_d    = tir_q;    op_d    = op_q;
    lrnw_d   = lrnw_q;    lapndp_d = lapndp_q; laddr_d = laddr_q;
    lwdata_d = lwdata_q;  cnt_d    = cnt_q;    lim_d   = lim_q;
    start    = 1'b0;      nst      = state_q;
    fin      = 1'b0;      fin_ack  = ACK_OK;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (req_go) begin
          busy_d   = 1'b1;
          op_d     = req_op;
          lrnw_d   = req_rnw;
          lapndp_d = req_apndp;
          laddr_d  = req_addr32;
          lwdata_d = req_wdata;
          lim_d    = wait_retries;
          cnt_d    = 16'd0;
          case (req_op)
            2'd0: begin
              tir_d = req_apndp ? IR_APACC : IR_DPACC;
              ret_d = XFER;
              start = 1'b1;
              nst   = (cvld_q && cir_q == tir_d) ? XFER : SETIR;
            end
            2'd1, 2'd2: begin
              start = 1'b1;
              nst   = CRST;
            end
            default: begin
              fin     = 1'b1;
              fin_ack = ACK_RSVD;
            end
          endcase
        end
      end
      default: begin
        if (lph_q == L_GO) begin
          if (!idle) begin
            go_d  = 1'b0;
            lph_d = L_RUN;
          end
        end else if (idle) begin
          // idle back high: this launch has finished, ack/dread are valid now
          case (state_q)
            SETIR: begin
              cvld_d = 1'b1;
              cir_d  = ir_q;
              start  = 1'b1;
              nst    = ret_q;
            end
            CRST: begin
              if (op_q == 2'd1) begin
                start = 1'b1;
                nst   = RDID;
              end else begin
                fin = 1'b1;
              end
            end
            RDID: begin
              cvld_d  = 1'b1;
              cir_d   = IR_IDCODE;
              rdata_d = dread;
              fin     = 1'b1;
            end
            XFER: begin
              if (ack == ACK_WAIT && cnt_q < lim_q) begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                start = 1'b1;
                nst   = XFER;
              end else if (ack == ACK_OK && lrnw_q) begin
                tir_d = IR_DPACC;
                cnt_d = 16'd0;
                ret_d = RDBUF;
                start = 1'b1;
                nst   = (cvld_q && cir_q == IR_DPACC) ? RDBUF : SETIR;
              end else begin
                fin     = 1'b1;
                fin_ack = ack;
              end
            end
            RDBUF: begin
              if (ack == ACK_WAIT && cnt_q < lim_q) begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                start = 1'b1;
                nst   = RDBUF;
              end else begin
                if (ack == ACK_OK) rdata_d = dread;
                fin     = 1'b1;
                fin_ack = ack;
              end
            end
            default: begin
              fin     = 1'b1;
              fin_ack = ACK_RSVD;
            end
          endcase
        end
      end
    endcase

    if (start) begin
      state_d = nst;
      lph_d   = L_GO;
      go_d    = 1'b1;
      case (nst)
        SETIR: begin
          cmd_d = CMD_IR;
          ir_d  = tir_d;
        end
        XFER: begin
          cmd_d    = CMD_TFR;
          rnw_d    = lrnw_d;
          apndp_d  = lapndp_d;
          addr_d   = laddr_d;
          dwrite_d = lwdata_d;
        end
        RDBUF: begin
          cmd_d   = CMD_TFR;
          rnw_d   = 1'b1;
          apndp_d = 1'b0;
          addr_d  = 2'd3;
        end
        CRST: begin
          cmd_d  = CMD_RST;
          cvld_d = 1'b0;
        end
        default: cmd_d = CMD_RID;
      endcase
    end

    if (fin) begin
      state_d = DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      rack_d  = fin_ack;
      go_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;   ret_q    <= XFER;   lph_q   <= L_GO;
      go_q     <= 1'b0;   cmd_q    <= 2'd0;   ir_q    <= 4'd0;
      rnw_q    <= 1'b0;   apndp_q  <= 1'b0;   addr_q  <= 2'd0;
      dwrite_q <= 32'd0;  busy_q   <= 1'b0;   done_q  <= 1'b0;
      rack_q   <= 3'd0;   rdata_q  <= 32'd0;  cvld_q  <= 1'b0;
      cir_q    <= 4'd0;   tir_q    <= 4'd0;   op_q    <= 2'd0;
      lrnw_q   <= 1'b0;   lapndp_q <= 1'b0;   laddr_q <= 2'd0;
      lwdata_q <= 32'd0;  cnt_q    <= 16'd0;  lim_q   <= WAITMAX;
    end else begin
      state_q  <= state_d;  ret_q    <= ret_d;    lph_q   <= lph_d;
      go_q     <= go_d;     cmd_q    <= cmd_d;    ir_q    <= ir_d;
      rnw_q    <= rnw_d;    apndp_q  <= apndp_d;  addr_q  <= addr_d;
      dwrite_q <= dwrite_d; busy_q   <= busy_d;   done_q  <= done_d;
      rack_q   <= rack_d;   rdata_q  <= rdata_d;  cvld_q  <= cvld_d;
      cir_q    <= cir_d;    tir_q    <= tir_d;    op_q    <= op_d;
      lrnw_q   <= lrnw_d;   lapndp_q <= lapndp_d; laddr_q <= laddr_d;
      lwdata_q <= lwdata_d; cnt_q    <= cnt_d;    lim_q   <= lim_d;
    end
  end

endmodule
